// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - store opcodes, error codes, FSM states and byte-count helpers
package mips_mem_pkg;

  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_FLAG = 2'd2
  } state_t;

  // Zero marks an opcode that is not a store.
  function automatic logic [2:0] byte_count(input logic [5:0] op);
    case (op)
      OP_SB:   byte_count = 3'd1;
      OP_SH:   byte_count = 3'd2;
      OP_SW:   byte_count = 3'd4;
      default: byte_count = 3'd0;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_SH:   is_aligned = (addr_lo[0] == 1'b0);
      OP_SW:   is_aligned = (addr_lo == 2'b00);
      default: is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_select.sv
// rtl/store_lane_select.sv - picks the big-endian byte of a store for a given byte index
module store_lane_select (
  input  logic [31:0] data,
  input  logic [2:0]  count,
  input  logic [1:0]  index,
  output logic [7:0]  lane
);

  // The most significant byte of the stored width goes out first.
  always_comb begin
    lane = data[7:0];
    case (count)
      3'd4: begin
        case (index)
          2'd0:    lane = data[31:24];
          2'd1:    lane = data[23:16];
          2'd2:    lane = data[15:8];
          default: lane = data[7:0];
        endcase
      end
      3'd2:    lane = index[0] ? data[7:0] : data[15:8];
      default: lane = data[7:0];
    endcase
  end

endmodule

// File: rtl/mem_store_serializer.sv
// rtl/mem_store_serializer.sv - serializes sb/sh/sw stores onto a byte-wide req/ack write bus
module mem_store_serializer
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [5:0]        st_opcode,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  state_t              state_q, state_d;
  logic [5:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          err_q, err_d;
  logic [2:0]          count;
  logic                last_byte;
  logic [7:0]          lane;

  assign count     = byte_count(op_q);
  assign last_byte = ({1'b0, idx_q} == (count - 3'd1));

  store_lane_select u_lane (
    .data  (data_q),
    .count (count),
    .index (idx_q),
    .lane  (lane)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    idx_d     = idx_q;
    err_d     = err_q;
    st_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = ERR_OK;

    case (state_q)
      ST_IDLE: begin
        st_ready = 1'b1;
        busy     = 1'b0;
        if (st_valid) begin
          op_d   = st_opcode;
          addr_d = st_addr;
          data_d = st_data;
          idx_d  = 2'd0;
          // An unknown opcode is reported even if its address is also misaligned.
          if (byte_count(st_opcode) == 3'd0) begin
            err_d   = ERR_ILLEGAL;
            state_d = ST_FLAG;
          end else if (!is_aligned(st_opcode, st_addr[1:0])) begin
            err_d   = ERR_MISALIGN;
            state_d = ST_FLAG;
          end else begin
            err_d   = ERR_OK;
            state_d = ST_XFER;
          end
        end
      end

      ST_XFER: begin
        mem_req   = 1'b1;
        // Aligned bases have zero low bits, so OR-ing the index never carries.
        mem_addr  = addr_q | {{(ADDR_W-2){1'b0}}, idx_q};
        mem_wdata = lane;
        if (mem_ack) begin
          if (last_byte) begin
            idx_d   = 2'd0;
            err_d   = ERR_OK;
            state_d = ST_FLAG;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      ST_FLAG: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_store_serializer.sv
// tb/tb_mem_store_serializer.sv - scoreboard bench for mem_store_serializer
module tb_mem_store_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [5:0]  st_opcode;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  mem_store_serializer #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_opcode (st_opcode),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [1:0] err;
    int         lat;
  } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    acc_q[$];
  int    cyc = 0;
  int    pass_cnt = 0;
  int    total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic flag(input string name);
    total_cnt++;
    $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_done(input logic [1:0] e, input int lat);
    done_t x;
    x.err = e;
    x.lat = lat;
    exp_done.push_back(x);
  endtask

  // Monitor: samples mid-cycle, checks every presented byte and every done pulse.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      acc_q.delete();
    end else begin
      if (mem_req) begin
        if (exp_wr.size() == 0) flag("unexpected_write");
        else begin
          chk("wr_addr", mem_addr, exp_wr[0].addr);
          chk("wr_data", {24'd0, mem_wdata}, {24'd0, exp_wr[0].data});
          if (mem_ack) void'(exp_wr.pop_front());
        end
      end
      if (done) begin
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_ready", {31'd0, st_ready}, 32'd0);
        chk("done_req", {31'd0, mem_req}, 32'd0);
        if (exp_done.size() == 0 || acc_q.size() == 0) flag("unexpected_done");
        else begin
          done_t x;
          int    a;
          x = exp_done.pop_front();
          a = acc_q.pop_front();
          chk("done_err", {30'd0, err}, {30'd0, x.err});
          chk("done_latency", cyc - a, x.lat);
        end
      end
      if (st_valid && st_ready) acc_q.push_back(cyc);
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, output int waits);
    logic r;
    st_valid  = 1'b1;
    st_opcode = op;
    st_addr   = a;
    st_data   = d;
    waits     = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      r = st_ready;
      @(posedge clk);
      if (r) break;
      waits++;
    end
    if (waits >= 100) flag("accept_timeout");
    #1;
    if (!hold) st_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0 || !st_ready) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 60) flag("idle_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_opcode = '0;
    st_addr   = '0;
    st_data   = '0;
    mem_ack   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {30'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // sw, zero-wait memory
    push_wr(32'h100, 8'hDE); push_wr(32'h101, 8'hAD);
    push_wr(32'h102, 8'hBE); push_wr(32'h103, 8'hEF);
    push_done(2'b00, 5);
    issue(6'h2B, 32'h100, 32'hDEADBEEF, 1'b0, w);
    wait_idle();

    // sh with the first byte held off for three cycles
    push_wr(32'h202, 8'hAB); push_wr(32'h203, 8'hCD);
    push_done(2'b00, 6);
    issue(6'h29, 32'h202, 32'h1234ABCD, 1'b0, w);
    mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mem_ack = 1'b1;
    wait_idle();

    // sb
    push_wr(32'h7, 8'h5A);
    push_done(2'b00, 2);
    issue(6'h28, 32'h7, 32'hFFFFFF5A, 1'b0, w);
    wait_idle();

    // error paths
    push_done(2'b01, 1);
    issue(6'h29, 32'h201, 32'h0, 1'b0, w);
    wait_idle();
    push_done(2'b01, 1);
    issue(6'h2B, 32'h102, 32'h0, 1'b0, w);
    wait_idle();
    push_done(2'b10, 1);
    issue(6'h23, 32'h100, 32'h0, 1'b0, w);
    wait_idle();
    push_done(2'b10, 1);
    issue(6'h23, 32'h3, 32'h0, 1'b0, w);
    wait_idle();

    // misaligned sh followed immediately by an sb: ready again two cycles after accept
    push_done(2'b01, 1);
    push_wr(32'h8, 8'h77);
    push_done(2'b00, 2);
    issue(6'h29, 32'h201, 32'h0, 1'b1, w);
    issue(6'h28, 32'h8, 32'h00000077, 1'b0, w);
    chk("err_gap_waits", w, 32'd1);
    wait_idle();

    // reset asserted while byte 2 of an sw is pending
    push_wr(32'h300, 8'h01); push_wr(32'h301, 8'h02); push_wr(32'h302, 8'h03);
    issue(6'h2B, 32'h300, 32'h01020304, 1'b0, w);
    repeat (2) @(posedge clk);
    #1;
    mem_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'd0, mem_req}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abandoned_bytes", exp_wr.size(), 32'd1);
    exp_wr.delete();
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {31'd0, st_ready}, 32'd1);

    push_wr(32'h10, 8'h55);
    push_done(2'b00, 2);
    issue(6'h28, 32'h10, 32'h00000055, 1'b0, w);
    wait_idle();

    // two sw back-to-back with st_valid held high
    push_wr(32'h400, 8'h11); push_wr(32'h401, 8'h22);
    push_wr(32'h402, 8'h33); push_wr(32'h403, 8'h44);
    push_done(2'b00, 5);
    push_wr(32'h404, 8'hA5); push_wr(32'h405, 8'hB6);
    push_wr(32'h406, 8'hC7); push_wr(32'h407, 8'hD8);
    push_done(2'b00, 5);
    issue(6'h2B, 32'h400, 32'h11223344, 1'b1, w);
    issue(6'h2B, 32'h404, 32'hA5B6C7D8, 1'b0, w);
    chk("b2b_waits", w, 32'd5);
    wait_idle();

    chk("left_writes", exp_wr.size(), 32'd0);
    chk("left_dones", exp_done.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_store_serializer.md
Name: mem_store_serializer

Overview:
- Narrowing counterpart to the core's immediate/load widening path.
- Takes a 32-bit store (sb/sh/sw) from the MIPS datapath and serializes it big-endian onto an 8-bit external data-memory write bus with a req/ack handshake.
- Checks alignment and opcode, and reports completion to the stall logic.
- Sits between the EX/MEM stage and the byte-wide data memory.

Parameters:
- ADDR_W, 32, width of byte address on both sides.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  block can accept a request (IDLE only).
- st_opcode  in  6  MIPS opcode: 6'h28 sb, 6'h29 sh, 6'h2B sw.
- st_addr  in  ADDR_W  byte address of store.
- st_data  in  32  register rt value to store.
- mem_req  out  1  byte write request.
- mem_addr  out  ADDR_W  byte address of current write.
- mem_wdata  out  8  byte being written.
- mem_ack  in  1  memory accepted current byte.
- busy  out  1  high whenever state is not IDLE (drives pipeline stall).
- done  out  1  one-cycle completion pulse.
- err  out  2  valid with done: 00 ok, 01 misaligned, 10 illegal opcode.

Behaviour:
- Reset values (async, on rst_n low): state IDLE, st_ready 1, mem_req 0, mem_addr 0, mem_wdata 0, busy 0, done 0, err 00, byte index 0.
- Reset mid-transfer: mem_req drops immediately, transfer abandoned, no done.
- Accept: st_valid && st_ready at rising edge T. Latch opcode, addr, data.
- Byte count: sb 1, sh 2, sw 4.
- Alignment rule: sh needs addr[0]=0; sw needs addr[1:0]=00; sb is always aligned.
- States:
  - IDLE: st_ready=1, busy=0. On accept:
    - illegal opcode -> FLAG with err=10.
    - legal but misaligned -> FLAG with err=01.
    - otherwise -> XFER, index=0.
    - Illegal opcode takes precedence over misalignment.
  - XFER: mem_req=1, mem_addr=base | index (index OR'd into low bits, no carry; alignment guarantees no wrap), mem_wdata=selected byte. mem_addr/mem_wdata are held stable until mem_ack is sampled high.
    - On ack with index < count-1: index+1, next byte presented the following cycle, mem_req stays high.
    - On ack of the last byte: -> FLAG, err=00.
  - FLAG: exactly one cycle. done=1, err valid, st_ready=0, busy=1, mem_req=0. Then -> IDLE.
- Big-endian byte order:
  - sw: index 0..3 -> data[31:24], [23:16], [15:8], [7:0].
  - sh: index 0..1 -> data[15:8], [7:0].
  - sb: data[7:0].
- Latency:
  - Request: mem_req first high at T+1.
  - Zero-wait memory (ack in the same cycle as req): sw done at T+5, sh T+3, sb T+2.
  - Error path: done at T+1, st_ready high again at T+2.
- mem_ack while mem_req=0 is ignored. Any number of ack wait cycles is allowed; no timeout.
- No memory traffic on error paths.
- Back-to-back requests: next accept is possible the cycle after FLAG.
- st_* inputs are ignored when st_ready=0.

Decomposition:
- Package mips_mem_pkg:
  - OP_SB=6'h28, OP_SH=6'h29, OP_SW=6'h2B.
  - ERR_OK/ERR_MISALIGN/ERR_ILLEGAL 2-bit constants.
  - State encoding IDLE/XFER/FLAG.
  - Helper function for byte count per opcode.
- One combinational sub-module, store_lane_select: inputs data[31:0], count, index[1:0]; output the byte per the big-endian rule above. Unit-testable standalone.

Test Plan:
- sw addr=0x100, data=0xDEADBEEF, ack always 1 -> bytes DE@0x100, AD@0x101, BE@0x102, EF@0x103 on consecutive cycles; done at T+5 with err=00.
- sh addr=0x202, data=0x1234ABCD; ack withheld 3 cycles on the first byte -> AB@0x202 held stable for 4 cycles, then CD@0x203; done with err=00.
- sb addr=0x7, data=0xFFFFFF5A -> single write 5A@0x7; done at T+2.
- sh addr=0x201 and sw addr=0x102 -> no mem_req, done at T+1 with err=01; opcode 6'h23 -> err=10.
- rst_n pulsed low during byte 2 of a sw -> mem_req low asynchronously, no done, st_ready=1 after release; next sb completes normally.
- Two sw issued back-to-back with st_valid held high -> second accepted the cycle after the first FLAG; byte stream uninterrupted except the FLAG/accept gap.
